// File: rtl/exception_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exception_ctrl_pkg
// Description : Shared exception cause codes, CP0 register indices, CP0 bit
//               positions, controller state encodings and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package exception_ctrl_pkg;

    // Exception cause codes (ExcCode field values)
    localparam logic [4:0] EXC_CAUSE_INT  = 5'd0;
    localparam logic [4:0] EXC_CAUSE_ADEL = 5'd4;
    localparam logic [4:0] EXC_CAUSE_ADES = 5'd5;
    localparam logic [4:0] EXC_CAUSE_SYS  = 5'd8;
    localparam logic [4:0] EXC_CAUSE_BP   = 5'd9;
    localparam logic [4:0] EXC_CAUSE_RI   = 5'd10;
    localparam logic [4:0] EXC_CAUSE_OV   = 5'd12;
    localparam logic [4:0] EXC_CAUSE_TRAP = 5'd13;

    // CP0 register indices
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // CP0 bit positions
    localparam int STATUS_IE_BIT   = 0;
    localparam int STATUS_EXL_BIT  = 1;
    localparam int STATUS_IM_LSB   = 8;
    localparam int CAUSE_EXC_LSB   = 2;
    localparam int CAUSE_IP_LSB    = 8;
    localparam int CAUSE_TI_BIT    = 30;
    localparam int CAUSE_BD_BIT    = 31;

    // Controller state encoding
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    // Return address recorded for an excepting instruction: a delay-slot
    // instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_target(input logic [31:0] pc,
                                               input logic        in_ds);
        return in_ds ? (pc - 32'd4) : pc;
    endfunction

    // Address-error causes are the only ones that capture BadVAddr.
    function automatic logic is_addr_exc(input logic [4:0] cause);
        return (cause == EXC_CAUSE_ADEL) || (cause == EXC_CAUSE_ADES);
    endfunction

endpackage
`default_nettype wire

// File: rtl/exception_ctrl_cp0_timer.sv
`default_nettype none
// ============================================================================
// Module      : cp0_timer
// Description : CP0 Count/Compare timer. Count advances every second cycle;
//               TI latches on Count == Compare (Compare non-zero) and is
//               cleared by any Compare write.
// Revision    : 1.0 - initial release
// ============================================================================
module cp0_timer (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);

    logic        r_toggle;
    logic [31:0] r_count;
    logic [31:0] r_compare;
    logic        r_ti;
    logic        w_match;

    assign w_match = (r_count == r_compare) && (r_compare != 32'd0);

    // Count register with half-rate toggle; a software write restarts the phase
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_toggle <= 1'b0;
            r_count  <= 32'd0;
        end else if (i_count_we) begin
            r_toggle <= 1'b0;
            r_count  <= i_wdata;
        end else begin
            r_toggle <= ~r_toggle;
            if (r_toggle) begin
                r_count <= r_count + 32'd1;
            end
        end
    end

    // Compare register and sticky timer-interrupt flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_compare <= 32'd0;
            r_ti      <= 1'b0;
        end else begin
            if (i_compare_we) begin
                r_compare <= i_wdata;
                r_ti      <= 1'b0;
            end else if (w_match) begin
                r_ti      <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;

endmodule
`default_nettype wire

// File: rtl/exception_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : exception_ctrl
// Description : MEM-stage exception/interrupt controller with CP0 register
//               file (BadVAddr, Count, Compare, Status, Cause, EPC), eret
//               handling and a one-cycle flush state.
// Revision    : 1.0 - initial release
// ============================================================================
module exception_ctrl
    import exception_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_MEM_valid,
    input  logic        i_MEM_exception_valid,
    input  logic [4:0]  i_MEM_exception_cause,
    input  logic [31:0] i_MEM_pc,
    input  logic        i_MEM_is_delay_slot,
    input  logic [31:0] i_MEM_bad_vaddr,
    input  logic        i_MEM_is_eret,
    input  logic        i_stall,
    input  logic [5:0]  i_ext_int,
    input  logic        i_cp0_we,
    input  logic [4:0]  i_cp0_waddr,
    input  logic [31:0] i_cp0_wdata,
    input  logic [4:0]  i_cp0_raddr,
    output logic [31:0] o_cp0_rdata,
    output logic        o_answer_exc,
    output logic [4:0]  o_exception_cause,
    output logic        o_is_eret,
    output logic [31:0] o_epc_value,
    output logic        o_flush
);

    logic [0:0]  r_state;
    logic [5:0]  r_int_s1;
    logic [5:0]  r_int_s2;
    logic [31:0] r_badvaddr;
    logic [31:0] r_epc;
    logic [7:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [4:0]  r_exccode;
    logic [1:0]  r_ip_sw;

    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic [7:0]  w_ip;
    logic        w_int_req;
    logic        w_slot_ok;
    logic        w_answer;
    logic        w_eret;
    logic [4:0]  w_cause;
    logic        w_cp0_wr;
    logic        w_count_we;
    logic        w_compare_we;
    logic [31:0] w_status;
    logic [31:0] w_cause_reg;
    logic [31:0] w_rdata;

    // Pending lines: IP[7] shares external line 5 with the timer interrupt
    assign w_ip      = {r_int_s2[5] | w_ti, r_int_s2[4:0], r_ip_sw};
    assign w_int_req = (|(w_ip & r_im)) & r_ie & ~r_exl;

    // An instruction can only be acted on when it is really retiring from MEM;
    // gating with i_rst_n keeps every output low while reset is held.
    assign w_slot_ok = i_rst_n & (r_state == ST_RUN) & ~i_stall & i_MEM_valid;
    assign w_answer  = w_slot_ok & (i_MEM_exception_valid | w_int_req);
    assign w_eret    = w_slot_ok & i_MEM_is_eret & ~w_answer;
    assign w_cause   = i_MEM_exception_valid ? i_MEM_exception_cause : EXC_CAUSE_INT;

    // An excepting or interrupted mtc0 must not commit its write
    assign w_cp0_wr     = i_rst_n & (r_state == ST_RUN) & i_cp0_we & ~i_stall & ~w_answer;
    assign w_count_we   = w_cp0_wr & (i_cp0_waddr == CP0_COUNT);
    assign w_compare_we = w_cp0_wr & (i_cp0_waddr == CP0_COMPARE);

    cp0_timer u_timer (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_count_we   (w_count_we),
        .i_compare_we (w_compare_we),
        .i_wdata      (i_cp0_wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    // Two-flop synchroniser for the asynchronous hardware interrupt lines
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_int_s1 <= 6'd0;
            r_int_s2 <= 6'd0;
        end else begin
            r_int_s1 <= i_ext_int;
            r_int_s2 <= r_int_s1;
        end
    end

    // RUN -> FLUSH on any redirect, FLUSH lasts exactly one cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_RUN;
        end else begin
            case (r_state)
                ST_RUN:   r_state <= (w_answer | w_eret) ? ST_FLUSH : ST_RUN;
                ST_FLUSH: r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    // CP0 state: exception entry has priority over eret, eret over mtc0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_badvaddr <= 32'd0;
            r_epc      <= 32'd0;
            r_im       <= 8'd0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_exccode  <= 5'd0;
            r_ip_sw    <= 2'd0;
        end else if (w_answer) begin
            r_exccode <= w_cause;
            r_exl     <= 1'b1;
            // A nested exception keeps the original return point
            if (!r_exl) begin
                r_epc <= epc_target(i_MEM_pc, i_MEM_is_delay_slot);
                r_bd  <= i_MEM_is_delay_slot;
            end
            if (i_MEM_exception_valid && is_addr_exc(i_MEM_exception_cause)) begin
                r_badvaddr <= i_MEM_bad_vaddr;
            end
        end else if (w_eret) begin
            r_exl <= 1'b0;
        end else if (w_cp0_wr) begin
            case (i_cp0_waddr)
                CP0_STATUS: begin
                    r_im  <= i_cp0_wdata[STATUS_IM_LSB +: 8];
                    r_exl <= i_cp0_wdata[STATUS_EXL_BIT];
                    r_ie  <= i_cp0_wdata[STATUS_IE_BIT];
                end
                CP0_CAUSE: begin
                    r_ip_sw <= i_cp0_wdata[CAUSE_IP_LSB +: 2];
                end
                CP0_EPC: begin
                    r_epc <= i_cp0_wdata;
                end
                default: begin
                end
            endcase
        end
    end

    // Assemble Status and Cause views from their fields
    always_comb begin
        w_status                         = 32'd0;
        w_status[STATUS_IM_LSB +: 8]     = r_im;
        w_status[STATUS_EXL_BIT]         = r_exl;
        w_status[STATUS_IE_BIT]          = r_ie;
        w_cause_reg                      = 32'd0;
        w_cause_reg[CAUSE_BD_BIT]        = r_bd;
        w_cause_reg[CAUSE_TI_BIT]        = w_ti;
        w_cause_reg[CAUSE_IP_LSB +: 8]   = w_ip;
        w_cause_reg[CAUSE_EXC_LSB +: 5]  = r_exccode;
    end

    // Combinational CP0 read port; unmapped indices read zero
    always_comb begin
        w_rdata = 32'd0;
        case (i_cp0_raddr)
            CP0_BADVADDR: w_rdata = r_badvaddr;
            CP0_COUNT:    w_rdata = w_count;
            CP0_COMPARE:  w_rdata = w_compare;
            CP0_STATUS:   w_rdata = w_status;
            CP0_CAUSE:    w_rdata = w_cause_reg;
            CP0_EPC:      w_rdata = r_epc;
            default:      w_rdata = 32'd0;
        endcase
    end

    assign o_cp0_rdata       = w_rdata;
    assign o_answer_exc      = w_answer;
    assign o_exception_cause = w_answer ? w_cause : 5'd0;
    assign o_is_eret         = w_eret;
    assign o_epc_value       = r_epc;
    assign o_flush           = w_answer | w_eret;

endmodule
`default_nettype wire

// File: tb/tb_exception_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_exception_ctrl
// Description : Self-checking bench for exception_ctrl using an expectation
//               queue filled when stimulus is driven and drained on sampling.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exception_ctrl;
    import exception_ctrl_pkg::*;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_MEM_valid;
    logic        i_MEM_exception_valid;
    logic [4:0]  i_MEM_exception_cause;
    logic [31:0] i_MEM_pc;
    logic        i_MEM_is_delay_slot;
    logic [31:0] i_MEM_bad_vaddr;
    logic        i_MEM_is_eret;
    logic        i_stall;
    logic [5:0]  i_ext_int;
    logic        i_cp0_we;
    logic [4:0]  i_cp0_waddr;
    logic [31:0] i_cp0_wdata;
    logic [4:0]  i_cp0_raddr;
    logic [31:0] o_cp0_rdata;
    logic        o_answer_exc;
    logic [4:0]  o_exception_cause;
    logic        o_is_eret;
    logic [31:0] o_epc_value;
    logic        o_flush;

    int          n_checks = 0;
    int          n_fail   = 0;
    string       tag_q[$];
    logic [31:0] val_q[$];

    exception_ctrl dut (
        .i_clk                 (i_clk),
        .i_rst_n               (i_rst_n),
        .i_MEM_valid           (i_MEM_valid),
        .i_MEM_exception_valid (i_MEM_exception_valid),
        .i_MEM_exception_cause (i_MEM_exception_cause),
        .i_MEM_pc              (i_MEM_pc),
        .i_MEM_is_delay_slot   (i_MEM_is_delay_slot),
        .i_MEM_bad_vaddr       (i_MEM_bad_vaddr),
        .i_MEM_is_eret         (i_MEM_is_eret),
        .i_stall               (i_stall),
        .i_ext_int             (i_ext_int),
        .i_cp0_we              (i_cp0_we),
        .i_cp0_waddr           (i_cp0_waddr),
        .i_cp0_wdata           (i_cp0_wdata),
        .i_cp0_raddr           (i_cp0_raddr),
        .o_cp0_rdata           (o_cp0_rdata),
        .o_answer_exc          (o_answer_exc),
        .o_exception_cause     (o_exception_cause),
        .o_is_eret             (o_is_eret),
        .o_epc_value           (o_epc_value),
        .o_flush               (o_flush)
    );

    initial i_clk = 1'b0;
    always #10 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        val_q.push_back(v);
    endtask

    task automatic sb_pop_check(input logic [31:0] got);
        string       t;
        logic [31:0] e;
        if (val_q.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            check_eq(t, got, e);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr_in();
        i_MEM_valid           = 1'b0;
        i_MEM_exception_valid = 1'b0;
        i_MEM_exception_cause = 5'd0;
        i_MEM_pc              = 32'd0;
        i_MEM_is_delay_slot   = 1'b0;
        i_MEM_bad_vaddr       = 32'd0;
        i_MEM_is_eret         = 1'b0;
        i_stall               = 1'b0;
        i_cp0_we              = 1'b0;
        i_cp0_waddr           = 5'd0;
        i_cp0_wdata           = 32'd0;
    endtask

    task automatic drv_exc(input logic [4:0] cause, input logic [31:0] pc,
                           input logic ds, input logic [31:0] bva);
        i_MEM_valid           = 1'b1;
        i_MEM_exception_valid = 1'b1;
        i_MEM_exception_cause = cause;
        i_MEM_pc              = pc;
        i_MEM_is_delay_slot   = ds;
        i_MEM_bad_vaddr       = bva;
    endtask

    // Expected answer/cause/eret/flush for the current cycle; cause only
    // matters when an exception is being answered
    task automatic exp_outs(input string tag, input logic a, input logic [4:0] c,
                            input logic e, input logic f);
        sb_push({tag, "_answer"}, 32'(a));
        if (a) sb_push({tag, "_cause"}, 32'(c));
        sb_push({tag, "_eret"}, 32'(e));
        sb_push({tag, "_flush"}, 32'(f));
        #1;
        sb_pop_check(32'(o_answer_exc));
        if (a) sb_pop_check(32'(o_exception_cause));
        sb_pop_check(32'(o_is_eret));
        sb_pop_check(32'(o_flush));
    endtask

    task automatic exp_reg(input string tag, input logic [4:0] addr, input logic [31:0] v);
        i_cp0_raddr = addr;
        sb_push(tag, v);
        #1;
        sb_pop_check(o_cp0_rdata);
    endtask

    task automatic exp_epc(input string tag, input logic [31:0] v);
        sb_push(tag, v);
        #1;
        sb_pop_check(o_epc_value);
    endtask

    task automatic cp0_wr(input logic [4:0] addr, input logic [31:0] data);
        i_cp0_we    = 1'b1;
        i_cp0_waddr = addr;
        i_cp0_wdata = data;
        tick();
        i_cp0_we    = 1'b0;
    endtask

    // Hard stop if the sequence ever stalls
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_ti;
        clr_in();
        i_rst_n     = 1'b0;
        i_ext_int   = 6'd0;
        i_cp0_raddr = 5'd0;
        repeat (2) @(posedge i_clk);
        #1;

        // Reset: outputs held low even with an exception presented
        drv_exc(EXC_CAUSE_SYS, 32'h100, 1'b0, 32'd0);
        i_MEM_is_eret = 1'b1;
        exp_outs("rst", 1'b0, 5'd0, 1'b0, 1'b0);
        exp_reg("rst_status", CP0_STATUS, 32'd0);
        exp_epc("rst_epc_out", 32'd0);
        clr_in();
        i_rst_n = 1'b1;
        tick();

        // SYS at 0x100, IE=0
        drv_exc(EXC_CAUSE_SYS, 32'h100, 1'b0, 32'hFFFF_0000);
        exp_outs("sys", 1'b1, EXC_CAUSE_SYS, 1'b0, 1'b1);
        tick();
        // FLUSH cycle: no answer, writes ignored
        i_cp0_we    = 1'b1;
        i_cp0_waddr = CP0_EPC;
        i_cp0_wdata = 32'hDEAD_0000;
        exp_outs("sys_flush", 1'b0, 5'd0, 1'b0, 1'b0);
        exp_reg("sys_epc", CP0_EPC, 32'h100);
        exp_reg("sys_status", CP0_STATUS, 32'h2);
        exp_reg("sys_cause", CP0_CAUSE, 32'h20);
        exp_reg("sys_badvaddr", CP0_BADVADDR, 32'd0);
        tick();
        clr_in();
        exp_reg("flush_wr_ignored", CP0_EPC, 32'h100);

        // OV in delay slot, then eret
        cp0_wr(CP0_STATUS, 32'd0);
        drv_exc(EXC_CAUSE_OV, 32'h204, 1'b1, 32'd0);
        exp_outs("ov", 1'b1, EXC_CAUSE_OV, 1'b0, 1'b1);
        tick();
        clr_in();
        tick();
        exp_reg("ov_epc", CP0_EPC, 32'h200);
        exp_reg("ov_cause", CP0_CAUSE, 32'h8000_0030);
        i_MEM_valid   = 1'b1;
        i_MEM_is_eret = 1'b1;
        exp_outs("eret", 1'b0, 5'd0, 1'b1, 1'b1);
        exp_epc("eret_epc", 32'h200);
        tick();
        clr_in();
        exp_reg("eret_status", CP0_STATUS, 32'd0);
        tick();

        // Nested exception under EXL keeps EPC/BD
        drv_exc(EXC_CAUSE_SYS, 32'h300, 1'b0, 32'd0);
        exp_outs("sys2", 1'b1, EXC_CAUSE_SYS, 1'b0, 1'b1);
        tick();
        clr_in();
        tick();
        drv_exc(EXC_CAUSE_RI, 32'h404, 1'b1, 32'd0);
        exp_outs("ri_exl", 1'b1, EXC_CAUSE_RI, 1'b0, 1'b1);
        tick();
        clr_in();
        exp_reg("ri_epc_kept", CP0_EPC, 32'h300);
        exp_reg("ri_cause", CP0_CAUSE, 32'h28);
        tick();
        cp0_wr(CP0_STATUS, 32'd0);

        // External interrupt: answered exactly two edges after the pulse
        cp0_wr(CP0_STATUS, 32'h401);
        i_MEM_valid = 1'b1;
        i_MEM_pc    = 32'h600;
        i_ext_int   = 6'b000001;
        exp_outs("int_c0", 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        i_ext_int = 6'd0;
        exp_outs("int_c1", 1'b0, 5'd0, 1'b0, 1'b0);
        tick();
        exp_outs("int_c2", 1'b1, EXC_CAUSE_INT, 1'b0, 1'b1);
        tick();
        clr_in();
        exp_reg("int_epc", CP0_EPC, 32'h600);
        exp_reg("int_status", CP0_STATUS, 32'h403);
        tick();
        // Same pulse with EXL=1: pending but not taken
        i_MEM_valid = 1'b1;
        i_MEM_pc    = 32'h640;
        i_ext_int   = 6'b000001;
        tick();
        i_ext_int = 6'd0;
        tick();
        exp_outs("int_exl", 1'b0, 5'd0, 1'b0, 1'b0);
        exp_reg("int_pending_ip", CP0_CAUSE, 32'h400);
        tick();
        clr_in();
        cp0_wr(CP0_STATUS, 32'd0);

        // Count: write, half-rate increment, wrap
        cp0_wr(CP0_COUNT, 32'h55);
        exp_reg("count_wr", CP0_COUNT, 32'h55);
        tick();
        tick();
        exp_reg("count_inc", CP0_COUNT, 32'h56);
        cp0_wr(CP0_COUNT, 32'hFFFF_FFFF);
        tick();
        tick();
        exp_reg("count_wrap", CP0_COUNT, 32'd0);

        // Timer interrupt: Compare=10, Count=0 -> TI after ~20 cycles
        cp0_wr(CP0_COMPARE, 32'd10);
        cp0_wr(CP0_COUNT, 32'd0);
        first_ti = 0;
        for (int n = 1; n <= 30; n++) begin
            tick();
            i_cp0_raddr = CP0_CAUSE;
            #1;
            if (o_cp0_rdata[30] && first_ti == 0) first_ti = n;
        end
        sb_push("ti_latency", 32'd1);
        sb_pop_check(32'((first_ti >= 20) && (first_ti <= 22)));
        cp0_wr(CP0_COMPARE, 32'h1000);
        exp_reg("ti_clear", CP0_CAUSE, 32'd0);

        // mtc0 Status with interrupt in the same cycle; stall blocks answer
        cp0_wr(CP0_STATUS, 32'h401);
        i_ext_int = 6'b000001;
        tick();
        tick();
        i_MEM_valid = 1'b1;
        i_MEM_pc    = 32'h700;
        i_stall     = 1'b1;
        exp_outs("stall", 1'b0, 5'd0, 1'b0, 1'b0);
        i_stall     = 1'b0;
        i_cp0_we    = 1'b1;
        i_cp0_waddr = CP0_STATUS;
        i_cp0_wdata = 32'd0;
        exp_outs("mtc0_int", 1'b1, EXC_CAUSE_INT, 1'b0, 1'b1);
        i_ext_int = 6'd0;
        tick();
        clr_in();
        exp_reg("mtc0_suppressed", CP0_STATUS, 32'h403);
        exp_reg("mtc0_int_epc", CP0_EPC, 32'h700);
        tick();
        cp0_wr(CP0_STATUS, 32'd0);
        tick();
        tick();

        // ADEL with eret in the same cycle: exception wins
        drv_exc(EXC_CAUSE_ADEL, 32'h500, 1'b0, 32'hDEAD_BEE1);
        i_MEM_is_eret = 1'b1;
        exp_outs("adel", 1'b1, EXC_CAUSE_ADEL, 1'b0, 1'b1);
        tick();
        exp_reg("adel_badvaddr", CP0_BADVADDR, 32'hDEAD_BEE1);
        exp_reg("adel_epc", CP0_EPC, 32'h500);

        // Reset asserted while in FLUSH
        i_rst_n = 1'b0;
        exp_outs("rst_flush", 1'b0, 5'd0, 1'b0, 1'b0);
        exp_reg("rst_flush_bva", CP0_BADVADDR, 32'd0);
        exp_reg("rst_flush_status", CP0_STATUS, 32'd0);
        exp_epc("rst_flush_epc", 32'd0);
        i_rst_n = 1'b1;
        exp_outs("rst_run", 1'b1, EXC_CAUSE_ADEL, 1'b0, 1'b1);
        tick();
        clr_in();
        exp_reg("unmapped", 5'd3, 32'd0);
        exp_reg("post_rst_epc", CP0_EPC, 32'h500);
        tick();

        check_eq("sb_empty", 32'(val_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 SHALL have ports: i_clk in 1 clock; i_rst_n in 1 reset, asynchronous, active-low; one clock domain only.
REQ-002 SHALL have inputs: i_MEM_valid 1 (non-bubble in MEM); i_MEM_exception_valid 1; i_MEM_exception_cause 5; i_MEM_pc 32; i_MEM_is_delay_slot 1; i_MEM_bad_vaddr 32; i_MEM_is_eret 1; i_stall 1; i_ext_int 6 (async hardware interrupts).
REQ-003 SHALL have CP0 access inputs: i_cp0_we 1 (mtc0 in MEM); i_cp0_waddr 5; i_cp0_wdata 32; i_cp0_raddr 5.
REQ-004 SHALL have outputs: o_cp0_rdata 32; o_answer_exc 1; o_exception_cause 5; o_is_eret 1; o_epc_value 32; o_flush 1 (kill IF..MEM).

Function
REQ-005 SHALL hold CP0 registers: BadVAddr(8), Count(9), Compare(11), Status(12; IM[15:8], EXL[1], IE[0], other bits read 0), Cause(13; BD[31], TI[30], IP[15:8], ExcCode[6:2]), EPC(14); any other address reads 0.
REQ-006 SHALL read o_cp0_rdata combinationally from i_cp0_raddr; Cause.IP[7:2] read the synchronised interrupt lines plus TI on IP[7].
REQ-007 SHALL synchronise each i_ext_int bit through two flops before use (2-cycle latency).
REQ-008 SHALL increment Count every second cycle (internal toggle bit), wrapping 0xFFFFFFFF -> 0.
REQ-009 SHALL set TI when Count == Compare (non-zero Compare) and clear TI on any Compare write.
REQ-010 SHALL raise an interrupt request when |(Cause.IP & Status.IM) && IE && !EXL.
REQ-011 SHALL assert o_answer_exc combinationally when FSM is RUN, i_stall=0, i_MEM_valid=1 and (i_MEM_exception_valid or interrupt request).
REQ-012 SHALL prioritise: synchronous exception > interrupt > eret; o_exception_cause = i_MEM_exception_cause for synchronous, EXC_CAUSE_INT for interrupt.
REQ-013 SHALL on answer edge: ExcCode <= cause; if EXL=0 then EPC <= delay_slot ? pc-4 : pc and BD <= delay_slot; EXL <= 1; BadVAddr <= i_MEM_bad_vaddr only for ADEL/ADES.
REQ-014 SHALL take synchronous exceptions while EXL=1 without updating EPC/BD.
REQ-015 SHALL assert o_is_eret when RUN, i_stall=0, i_MEM_valid, i_MEM_is_eret and no answer; o_epc_value = EPC register; on that edge EXL <= 0.
REQ-016 SHALL drive o_flush = o_answer_exc | o_is_eret.
REQ-017 SHALL perform the CP0 write at the edge only when i_cp0_we, i_stall=0 and no answer that cycle (excepting/interrupted instruction writes nothing); Count write restarts the toggle.
REQ-018 SHALL implement FSM RUN -> FLUSH on answer or eret; FLUSH -> RUN after exactly one cycle; in FLUSH o_answer_exc=0, o_is_eret=0, writes ignored.
REQ-019 SHALL keep Count/TI/synchronisers running during i_stall and FLUSH.

Reset
REQ-020 SHALL on i_rst_n=0 immediately clear all CP0 registers, synchronisers, Count toggle, FSM -> RUN; all outputs 0 while in reset (o_cp0_rdata 0).
REQ-021 SHALL discard any exception in progress when reset asserts mid-cycle; no partial EPC update.

Structure
REQ-022 SHALL take cause codes from the shared exception definitions include (INT=0, ADEL=4, ADES=5, SYS=8, BP=9, RI=10, OV=12, TRAP=13); CP0 indices and bit positions SHALL be added to a shared CP0 definitions include.
REQ-023 SHALL place Count/Compare/TI in sub-module cp0_timer; all else in exception_ctrl.

Verification
REQ-024 SYS at pc 0x100, not delay slot, IE=0 -> o_answer_exc=1, cause 8, next edge EPC=0x100, EXL=1, FLUSH one cycle.
REQ-025 OV at pc 0x204 in delay slot -> EPC=0x200, BD=1; then eret -> o_is_eret=1, o_epc_value=0x200, EXL=0.
REQ-026 IE=1, IM=0x04, i_ext_int[0] pulse -> answer cause 0 exactly 2 cycles later on first valid, unstalled instruction; same with EXL=1 -> no answer.
REQ-027 Compare=10, Count=0 -> TI set after 20 cycles; Compare write -> TI clear.
REQ-028 mtc0 Status plus interrupt same cycle -> write suppressed; ADEL with eret same cycle -> exception wins, BadVAddr updated; reset asserted during FLUSH -> all zero, RUN.
